// File: rtl/video_timing_ctrl.sv
// Raster sequencer: counters, DE window, syncs, pixel pull and underflow fill.
// Ports: pixel_clk/rst_n, enable, pix_* handshake, x/y, de/hsync/vsync, pixel_*, underflow.
module video_timing_ctrl #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter logic        HSYNC_POL  = 1'b0,
  parameter logic        VSYNC_POL  = 1'b0,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        frame_start,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  pixel_r,
  output logic [7:0]  pixel_g,
  output logic [7:0]  pixel_b,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // 13-bit bounds so a 4096 total still compares correctly
  localparam logic [12:0] H_ACT = 13'(H_ACTIVE);
  localparam logic [12:0] H_SS  = 13'(H_ACTIVE + H_FRONT);
  localparam logic [12:0] H_SE  = 13'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [12:0] H_LST = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT = 13'(V_ACTIVE);
  localparam logic [12:0] V_SS  = 13'(V_ACTIVE + V_FRONT);
  localparam logic [12:0] V_SE  = 13'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [12:0] V_LST = 13'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [23:0] pixel_q, pixel_d;
  logic        underflow_q, underflow_d;

  logic [12:0] h_w, v_w;
  logic        run, active, h_last, v_last;
  logic        hs_reg, vs_reg;

  assign h_w    = {1'b0, h_cnt_q};
  assign v_w    = {1'b0, v_cnt_q};
  assign run    = (state_q == RUN);
  assign active = run && (h_w < H_ACT) && (v_w < V_ACT);
  assign h_last = (h_w == H_LST);
  assign v_last = (v_w == V_LST);
  assign hs_reg = run && (h_w >= H_SS) && (h_w < H_SE);
  assign vs_reg = run && (v_w >= V_SS) && (v_w < V_SE);

  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    unique case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (h_last) begin
          h_cnt_d = '0;
          if (v_last) begin
            v_cnt_d = '0;
            // enable is only sampled at frame end
            if (!enable) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 12'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 12'd1;
        end
      end
    endcase

    de_d    = active;
    hsync_d = hs_reg ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = vs_reg ? VSYNC_POL : ~VSYNC_POL;
    pixel_d = '0;
    if (active) pixel_d = pix_valid ? pix_data : FILL_COLOR;
    underflow_d = underflow_q;
    if (underflow_clr) underflow_d = 1'b0;
    // a new underflow beats a simultaneous clear
    if (active && !pix_valid) underflow_d = 1'b1;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      pixel_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      pixel_q     <= pixel_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix_ready   = active;
  assign frame_start = run && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixel_r     = pixel_q[23:16];
  assign pixel_g     = pixel_q[15:8];
  assign pixel_b     = pixel_q[7:0];
  assign underflow   = underflow_q;

endmodule
